// File: rtl/tpiu_pkg.sv
// Shared constants and FSM encoding for the TPIU capture sequencer.
// Synch patterns come from the TPIU formatter protocol.
package tpiu_pkg;

    localparam logic [31:0] SYNCH_PACKET      = 32'h7FFF_FFFF;
    localparam logic [31:0] HALF_SYNCH_PACKET = 32'h7FFF_7FFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/tpiu_sync_fifo.sv
// Small synchronous FIFO with a registered head word.
// A pop and a push in the same cycle never frees space early.
module tpiu_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/tpiu_capture_ctrl.sv
// TPIU capture session sequencer: sync hunt, FIFO forwarding,
// and half-synch padding so every AXI-Stream packet is full length.
module tpiu_capture_ctrl
    import tpiu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BURST_BEATS = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEN_W       = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              START,
    input  logic              STOP,
    input  logic [LEN_W-1:0]  CAPTURE_LEN,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    input  logic              TREADY,
    output logic [DATA_W-1:0] TDATA,
    output logic              TVALID,
    output logic              TLAST,
    output logic              BUSY,
    output logic              DONE,
    output logic [LEN_W-1:0]  WORD_COUNT,
    output logic [LEN_W-1:0]  DROP_COUNT
);

    localparam int BEAT_W = $clog2(BURST_BEATS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] SYNCH_W = DATA_W'(SYNCH_PACKET);
    localparam logic [DATA_W-1:0] HALF_W  = DATA_W'(HALF_SYNCH_PACKET);

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [LEN_W-1:0]  word_count_q;
    logic [LEN_W-1:0]  drop_count_q;
    logic [LEN_W-1:0]  len_q;
    logic [BEAT_W-1:0] push_cnt_q;
    logic [BEAT_W-1:0] pop_cnt_q;

    logic              fifo_push;
    logic [DATA_W-1:0] fifo_wdata;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              sess_start;
    logic              word_push;
    logic              word_drop;
    logic              in_synch;
    logic              len_hit;
    logic              beat_pop;

    assign in_synch = (IN_DATA == SYNCH_W) || (IN_DATA == HALF_W);
    assign len_hit  = (len_q != '0) && (word_count_q + LEN_W'(1) == len_q);
    assign beat_pop = TVALID && TREADY;

    always_comb begin
        state_d    = state_q;
        fifo_push  = 1'b0;
        fifo_wdata = IN_DATA;
        sess_start = 1'b0;
        word_push  = 1'b0;
        word_drop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sess_start = 1'b1;
                    state_d    = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (STOP) begin
                    state_d = ST_DONE;
                end else if (IN_VALID && IN_DATA == SYNCH_W) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (IN_VALID && !in_synch) begin
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                        word_push = 1'b1;
                    end else begin
                        word_drop = 1'b1;
                    end
                end
                if (STOP || (word_push && len_hit)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // pad until the packet is whole, then drain
                if (push_cnt_q != '0) begin
                    if (!fifo_full) begin
                        fifo_push  = 1'b1;
                        fifo_wdata = HALF_W;
                    end
                end else if (fifo_count == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            drop_count_q <= '0;
            len_q        <= '0;
            push_cnt_q   <= '0;
            pop_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (sess_start) begin
                word_count_q <= '0;
                drop_count_q <= '0;
                len_q        <= CAPTURE_LEN;
                push_cnt_q   <= '0;
                pop_cnt_q    <= '0;
            end else begin
                if (word_push) begin
                    word_count_q <= word_count_q + LEN_W'(1);
                end
                if (word_drop && drop_count_q != '1) begin
                    drop_count_q <= drop_count_q + LEN_W'(1);
                end
                if (fifo_push) begin
                    push_cnt_q <= push_cnt_q + BEAT_W'(1);
                end
                if (beat_pop) begin
                    pop_cnt_q <= pop_cnt_q + BEAT_W'(1);
                end
            end
        end
    end

    tpiu_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (TREADY),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign TDATA      = fifo_head;
    assign TVALID     = !fifo_empty;
    assign TLAST      = TVALID && (pop_cnt_q == BEAT_W'(BURST_BEATS - 1));
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = (state_q == ST_DONE);
    assign WORD_COUNT = word_count_q;
    assign DROP_COUNT = drop_count_q;

endmodule
